divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Iterative radix-2 restoring divider implementing RV32M DIV/DIVU/REM/REMU.
//  Inverse companion of the single-cycle multiplier in the EX stage; selected by alu_op.
//  Multi-cycle: EX stalls on busy and consumes div_result when done pulses.
// PARAMETERS
//  XLEN   32   operand/result width; iteration count = XLEN
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only when busy=0
//  flush       in   1      abort in-flight op (pipeline flush/trap)
//  alu_op      in   4      `ALU_DIV / `ALU_DIVU / `ALU_REM / `ALU_REMU
//  operand_a   in   XLEN   dividend
//  operand_b   in   XLEN   divisor
//  busy        out  1      op accepted, result not yet delivered
//  done        out  1      one-cycle pulse; div_result valid this cycle
//  div_result  out  XLEN   quotient or remainder; held until next accepted start
// BEHAVIOUR
//  - Reset (async): state=IDLE, busy=0, done=0, div_result=0, all datapath regs 0.
//  - FSM states:
//      IDLE: waits for start.
//      CALC: one iteration per cycle.
//      FIN:  sign fixup and result select.
//  - Start accepted at edge T:
//    - Latch op, |a|, |b| (abs only for DIV/REM), quotient sign = a[31]^b[31], remainder sign = a[31].
//    - count=0; busy=1.
//  - CALC: partial remainder {rem,quo} shift-left by 1; trial subtract divisor.
//    - Non-negative: keep the difference, quo LSB=1.
//    - Otherwise: restore, quo LSB=0.
//    - count++; leave CALC at edge T+XLEN.
//  - FIN (edge T+XLEN+1): div_result <= signed-fixed quotient or remainder; done=1 for one cycle.
//    - busy=0 at the same edge; state->IDLE.
//    - Normal latency: start edge T -> done high in the cycle after edge T+33.
//  - Special cases resolve at edge T, go straight to FIN, done after edge T+1:
//    - divisor=0: DIV/DIVU -> all-ones; REM/REMU -> operand_a.
//    - DIV/REM with a=0x80000000, b=-1: DIV -> 0x80000000; REM -> 0.
//    - Any other alu_op: result 0.
//  - Sign fixup: quotient negated if qsign (DIV only); remainder negated if rsign (REM only).
//    - Remainder sign always follows the dividend.
//  - start while busy=1: ignored; no effect on the in-flight op.
//  - flush: any state -> IDLE next edge; busy=0; done not asserted; div_result unchanged.
//  - flush and start in the same cycle: flush wins, start dropped.
//  - done and start in the same cycle: the new start is accepted (busy=0 in that cycle).
//  - rst mid-operation: immediate return to reset values; no done.
// STRUCTURE
//  - `ALU_DIV/`ALU_DIVU/`ALU_REM/`ALU_REMU codes (4-bit, distinct from the MUL codes) live in defines.v.
//  - FSM state encodings are local constants.
//  - Single module, no sub-module; iteration counter is $clog2(XLEN)+1 bits.
// TESTING
//  - DIV 100/7 -> 14 (0x0E) after edge T+33; REM 100/7 -> 2.
//  - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  - Divide by zero, a=0x1234: DIV -> 0xFFFFFFFF, REM -> 0x1234, done after edge T+1.
//  - Overflow 0x80000000/0xFFFFFFFF: DIV -> 0x80000000, REM -> 0, done after T+1.
//  - flush at cycle T+10: no done, busy=0 next cycle; new start at T+12 completes normally.
//  - start pulsed while busy: ignored, original result delivered.
//  - rst asserted mid-CALC: outputs zero immediately, no done.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared opcodes, FSM states and opcode helpers for the RV32M iterative divider.
package divider_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_DIV  = 4'd8;
  localparam logic [OP_W-1:0] ALU_DIVU = 4'd9;
  localparam logic [OP_W-1:0] ALU_REM  = 4'd10;
  localparam logic [OP_W-1:0] ALU_REMU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_e;

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface divider_if
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [OP_W-1:0] alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] div_result;

  modport master (
    output start, flush, alu_op, operand_a, operand_b,
    input  busy, done, div_result
  );

  modport slave (
    input  start, flush, alu_op, operand_a, operand_b,
    output busy, done, div_result
  );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per
// cycle, special cases resolved at acceptance and routed straight to FIN.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  divider_if.slave   bus
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic            done_q, done_d;

  logic            sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] min_neg;
  logic [XLEN:0]   trial;

  assign min_neg = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    op_d    = op_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    done_d  = 1'b0;
    trial   = '0;

    sgn   = is_signed_op(bus.alu_op);
    a_neg = sgn && bus.operand_a[XLEN-1];
    b_neg = sgn && bus.operand_b[XLEN-1];
    a_abs = a_neg ? -bus.operand_a : bus.operand_a;
    b_abs = b_neg ? -bus.operand_b : bus.operand_b;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.alu_op;
          count_d = '0;
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          state_d = ST_CALC;
          // Specials preload the final magnitude with signs cleared so FIN's
          // ordinary select/fixup yields the architectural result unchanged.
          if (!is_div_op(bus.alu_op)) begin
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = ST_FIN;
          end else if (bus.operand_b == '0) begin
            quo_d   = '1;
            rem_d   = bus.operand_a;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = ST_FIN;
          end else if (sgn && (bus.operand_a == min_neg) && (bus.operand_b == '1)) begin
            quo_d   = min_neg;
            rem_d   = '0;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = ST_FIN;
          end
        end
      end

      ST_CALC: begin
        // rem < divisor on entry, so bit XLEN of the trial is purely the borrow.
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(XLEN - 1)) begin
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (op_q)
          ALU_DIV:  res_d = qsign_q ? -quo_q : quo_q;
          ALU_DIVU: res_d = quo_q;
          ALU_REM:  res_d = rsign_q ? -rem_q : rem_q;
          ALU_REMU: res_d = rem_q;
          default:  res_d = '0;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      op_q    <= op_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.div_result = res_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, hand-written multi-cycle
// sequences, and randomized ops against an arithmetic reference model.
module tb_divider;
  import divider_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  divider_if #(.XLEN(32)) bus ();

  divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      ALU_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic sgn;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    if (!(sgn || op == ALU_DIVU || op == ALU_REMU)) return 1;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Counts edges after the current point until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.alu_op    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    launch(op, a, b);
    wait_done(lat);
    res = bus.div_result;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          lat;
    int          seen;

    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.alu_op    = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    vecs[0]  = '{ALU_DIV,  32'd100,        32'd7,          32'h0000_000E, 33};
    vecs[1]  = '{ALU_REM,  32'd100,        32'd7,          32'h0000_0002, 33};
    vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33};
    vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33};
    vecs[4]  = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF, 33};
    vecs[5]  = '{ALU_DIV,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 1};
    vecs[6]  = '{ALU_REM,  32'h0000_1234,  32'd0,          32'h0000_1234, 1};
    vecs[7]  = '{ALU_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 1};
    vecs[8]  = '{ALU_REMU, 32'hFFFF_1234,  32'd0,          32'hFFFF_1234, 1};
    vecs[9]  = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
    vecs[10] = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
    vecs[11] = '{ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33};
    vecs[12] = '{ALU_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33};
    vecs[13] = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 33};
    vecs[14] = '{4'h0,     32'd100,        32'd7,          32'h0000_0000, 1};
    vecs[15] = '{ALU_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000, 33};

    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
    end

    @(posedge clk);
    #1;
    chk("done_single_cycle", 32'(bus.done), 32'd0);

    // Flush at T+10 drops the op; a new start at T+12 completes normally.
    held = bus.div_result;
    launch(ALU_DIV, 32'd100, 32'd7);
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy_after", 32'(bus.busy), 32'd0);
    chk("flush_no_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_no_done_next", 32'(bus.done), 32'd0);
    chk("flush_result_held", bus.div_result, held);
    do_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd2, res, lat);
    chk("after_flush_result", res, 32'h7FFF_FFFF);
    chk("after_flush_latency", 32'(lat), 32'd33);

    // Flush and start together: start is dropped.
    @(negedge clk);
    bus.alu_op    = ALU_DIV;
    bus.operand_a = 32'd50;
    bus.operand_b = 32'd5;
    bus.start     = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("flush_start_no_done", 32'(seen), 32'd0);

    // Start pulsed while busy must not disturb the in-flight op.
    launch(ALU_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.alu_op    = ALU_DIVU;
    bus.operand_a = 32'd50;
    bus.operand_b = 32'd5;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("busy_start_result", bus.div_result, 32'h0000_000E);
    chk("busy_start_latency", 32'(lat), 32'd28);

    // Start in the done cycle is accepted immediately.
    bus.alu_op    = ALU_REM;
    bus.operand_a = 32'hFFFF_FFF9;
    bus.operand_b = 32'd2;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("done_start_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("done_start_result", bus.div_result, 32'hFFFF_FFFF);
    chk("done_start_latency", 32'(lat), 32'd33);

    // Asynchronous reset mid-CALC.
    launch(ALU_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_result", bus.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("rst_mid_no_done", 32'(seen), 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = ALU_DIV + 4'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        4:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 50);
      do_op(op, a, b, res, lat);
      chk($sformatf("rand%0d_op%0d_%08h_%08h", i, op, a, b), res, ref_result(op, a, b));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
